// File: rtl/me_pel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : me_pel_feeder
//  Description : Source end of the PE pel/enable interface for the full-search
//                motion-estimation array. Reads the NxN template block (TB)
//                and the (N+2R)^2 search window (SW) from two external
//                synchronous-read RAMs. It first feeds the TB chain, then
//                streams the SW once for every vertical candidate offset.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       clock
//    rst_n     asynchronous active-low reset
//    start     begin one search (sampled only while idle)
//    stall     downstream hold; freezes every counter, state and pipe stage
//    busy      search in progress
//    done      one-cycle pulse when the last SW beat has been emitted
//    tb_ren    TB RAM read enable      tb_addr  TB RAM address (raster)
//    tb_rdata  TB RAM read data (one cycle after tb_ren)
//    sw_ren    SW RAM read enable      sw_addr  SW RAM address (raster)
//    sw_rdata  SW RAM read data (one cycle after sw_ren)
//    pel_tb    TB pel to the array     en_tb    pel_tb valid / shift TB
//    pel_sw    SW pel to the array     en_sw    pel_sw valid / shift SW
//    sw_sol    first pixel of an SW row (qualified by en_sw)
//    sw_eol    last pixel of an SW row  (qualified by en_sw)
//    cand_dy   vertical candidate offset of the current en_sw beat
// ============================================================================
module me_pel_feeder #(
    parameter  int N     = 16,
    parameter  int R     = 8,
    localparam int SW_W  = N + 2*R,
    localparam int TBA_W = $clog2(N*N),
    localparam int SWA_W = $clog2(SW_W*SW_W),
    localparam int DY_W  = $clog2(2*R+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             tb_ren,
    output logic [TBA_W-1:0] tb_addr,
    input  logic [7:0]       tb_rdata,
    output logic             sw_ren,
    output logic [SWA_W-1:0] sw_addr,
    input  logic [7:0]       sw_rdata,
    output logic [7:0]       pel_tb,
    output logic             en_tb,
    output logic [7:0]       pel_sw,
    output logic             en_sw,
    output logic             sw_sol,
    output logic             sw_eol,
    output logic [DY_W-1:0]  cand_dy
);

    // ------------------------------------------------------------------------
    // Local widths and terminal values
    // ------------------------------------------------------------------------
    localparam int ROW_W = $clog2(N);
    localparam int COL_W = $clog2(SW_W);

    localparam logic [TBA_W-1:0] C_TB_LAST   = TBA_W'(N*N-1);
    localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(N-1);
    localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(SW_W-1);
    localparam logic [DY_W-1:0]  C_DY_LAST   = DY_W'(2*R);
    localparam logic [SWA_W-1:0] C_SW_STRIDE = SWA_W'(SW_W);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD_TB = 2'd1;
    localparam logic [1:0] S_SCAN    = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    // ------------------------------------------------------------------------
    // State, address counters and read-pipeline stage
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [TBA_W-1:0] r_tb_cnt;
    logic [DY_W-1:0]  r_dy;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_done;

    // Registered copies of the read enables plus the beat side-band, aligned
    // with the RAM data that appears one cycle after the read.
    logic             r_v_tb;
    logic             r_v_sw;
    logic             r_sol_d;
    logic             r_eol_d;
    logic [DY_W-1:0]  r_dy_d;

    logic             w_in_load;
    logic             w_in_scan;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_dy_last;
    logic [SWA_W-1:0] w_sw_row;

    assign w_in_load  = (r_state == S_LOAD_TB);
    assign w_in_scan  = (r_state == S_SCAN);
    assign w_col_last = (r_col == C_COL_LAST);
    assign w_row_last = (r_row == C_ROW_LAST);
    assign w_dy_last  = (r_dy  == C_DY_LAST);

    // ------------------------------------------------------------------------
    // Control FSM and address counters. Nothing but the idle->load decision
    // moves while stall is high; the start pulse is honoured even when stall
    // is asserted so that it is never lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_tb_cnt <= '0;
            r_dy     <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD_TB;
                    end
                end
                S_LOAD_TB: begin
                    if (!stall) begin
                        if (r_tb_cnt == C_TB_LAST) begin
                            r_tb_cnt <= '0;
                            r_state  <= S_SCAN;
                        end else begin
                            r_tb_cnt <= r_tb_cnt + TBA_W'(1);
                        end
                    end
                end
                S_SCAN: begin
                    // Column is the fastest index, then row inside the
                    // candidate band, then the vertical candidate offset.
                    if (!stall) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row <= '0;
                                if (w_dy_last) begin
                                    r_dy    <= '0;
                                    r_state <= S_DRAIN;
                                end else begin
                                    r_dy <= r_dy + DY_W'(1);
                                end
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // The last SW read is sitting in the RAM output; it leaves
                    // on the first unstalled cycle, which is also when the
                    // search is reported complete.
                    if (!stall) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline. While stalled the RAMs are not read, so their outputs
    // hold the last word; keeping the valid flags frozen lets that word be
    // emitted exactly once when the stall lifts.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_tb  <= 1'b0;
            r_v_sw  <= 1'b0;
            r_sol_d <= 1'b0;
            r_eol_d <= 1'b0;
            r_dy_d  <= '0;
        end else if (!stall) begin
            r_v_tb  <= w_in_load;
            r_v_sw  <= w_in_scan;
            r_sol_d <= w_in_scan && (r_col == '0);
            r_eol_d <= w_in_scan && w_col_last;
            r_dy_d  <= w_in_scan ? r_dy : '0;
        end
    end

    // ------------------------------------------------------------------------
    // SW address: row (dy + r) of the window, column c. The largest row index
    // is 2R+N-1 = SW_W-1, so the result stays within SW_W*SW_W-1.
    // ------------------------------------------------------------------------
    assign w_sw_row = SWA_W'(r_dy) + SWA_W'(r_row);
    assign sw_addr  = w_sw_row * C_SW_STRIDE + SWA_W'(r_col);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;

    assign tb_ren  = w_in_load & ~stall;
    assign tb_addr = r_tb_cnt;
    assign sw_ren  = w_in_scan & ~stall;

    assign pel_tb  = tb_rdata;
    assign pel_sw  = sw_rdata;
    assign en_tb   = r_v_tb & ~stall;
    assign en_sw   = r_v_sw & ~stall;

    assign sw_sol  = r_sol_d & en_sw;
    assign sw_eol  = r_eol_d & en_sw;
    assign cand_dy = en_sw ? r_dy_d : '0;

endmodule
`default_nettype wire

// File: tb/tb_me_pel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_me_pel_feeder
//  Description : Self-checking bench for me_pel_feeder with N=4, R=1
//                (SW_W=6, 16 TB beats, 72 SW beats). Expected pel streams
//                are queued when a search is started and popped as the
//                design emits beats; per-run timing comes from a table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_me_pel_feeder;

    localparam int N     = 4;
    localparam int R     = 1;
    localparam int SW_W  = N + 2*R;
    localparam int TBA_W = $clog2(N*N);
    localparam int SWA_W = $clog2(SW_W*SW_W);
    localparam int DY_W  = $clog2(2*R+1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stall;
    logic             busy;
    logic             done;
    logic             tb_ren;
    logic [TBA_W-1:0] tb_addr;
    logic [7:0]       tb_rdata = '0;
    logic             sw_ren;
    logic [SWA_W-1:0] sw_addr;
    logic [7:0]       sw_rdata = '0;
    logic [7:0]       pel_tb;
    logic             en_tb;
    logic [7:0]       pel_sw;
    logic             en_sw;
    logic             sw_sol;
    logic             sw_eol;
    logic [DY_W-1:0]  cand_dy;

    int n_checks = 0;
    int n_errors = 0;

    int tbq[$];
    int swq[$];

    typedef struct {
        int s1_at;   int s1_len;      // first stall window (period, length)
        int s2_at;   int s2_len;      // second stall window
        int st2a;    int st2b;        // extra start pulses while busy
        int first_tb; int first_sw; int last_sw; int done_at;
    } run_t;

    run_t runs[5];

    me_pel_feeder #(.N(N), .R(R)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .tb_ren   (tb_ren),
        .tb_addr  (tb_addr),
        .tb_rdata (tb_rdata),
        .sw_ren   (sw_ren),
        .sw_addr  (sw_addr),
        .sw_rdata (sw_rdata),
        .pel_tb   (pel_tb),
        .en_tb    (en_tb),
        .pel_sw   (pel_sw),
        .en_sw    (en_sw),
        .sw_sol   (sw_sol),
        .sw_eol   (sw_eol),
        .cand_dy  (cand_dy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tb_val(input int a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    function automatic int sw_pack(input int v, input int sol, input int eol, input int dy);
        return (dy << 10) | (eol << 9) | (sol << 8) | v;
    endfunction

    // Synchronous-read RAMs: data appears the cycle after the enable and is
    // held while the enable is low. SW RAM content equals its address.
    always @(posedge clk) begin
        if (tb_ren) tb_rdata <= tb_val(int'(tb_addr));
        if (sw_ren) sw_rdata <= 8'(sw_addr);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event", name);
    endtask

    function automatic bit in_win(input int t, input int at, input int len);
        return (at >= 0) && (t >= at) && (t < at + len);
    endfunction

    // One search: start is driven in period 0; periods are counted from the
    // clock edge that samples start.
    task automatic run_one(input run_t rc, input int idx);
        int t, ftb, fsw, lsw, dt, dcnt, bfirst, blast;
        bit finished;
        for (int a = 0; a < N*N; a++) tbq.push_back(int'(tb_val(a)));
        for (int dy = 0; dy <= 2*R; dy++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < SW_W; c++)
                    swq.push_back(sw_pack((dy + r) * SW_W + c, int'(c == 0),
                                          int'(c == SW_W-1), dy));
        ftb = -1; fsw = -1; lsw = -1; dt = -1; dcnt = 0; bfirst = -1; blast = -1;
        finished = 1'b0;
        t = 0;
        while (!finished && t < 400) begin
            @(posedge clk); #1;
            start = (t == 0) || (t == rc.st2a) || (t == rc.st2b);
            stall = in_win(t, rc.s1_at, rc.s1_len) || in_win(t, rc.s2_at, rc.s2_len);
            @(negedge clk);
            if (en_tb) begin
                if (ftb < 0) ftb = t;
                if (tbq.size() == 0) fail_now($sformatf("run%0d tb_extra_beat", idx));
                else chk($sformatf("run%0d pel_tb", idx), int'(pel_tb), tbq.pop_front());
            end
            if (en_sw) begin
                if (fsw < 0) fsw = t;
                lsw = t;
                if (swq.size() == 0) fail_now($sformatf("run%0d sw_extra_beat", idx));
                else chk($sformatf("run%0d sw_beat", idx),
                         sw_pack(int'(pel_sw), int'(sw_sol), int'(sw_eol), int'(cand_dy)),
                         swq.pop_front());
            end else begin
                chk($sformatf("run%0d sw_sideband_gate", idx),
                    int'({sw_sol, sw_eol, cand_dy}), 0);
            end
            if (sw_ren) chk($sformatf("run%0d sw_addr_range", idx),
                            int'(sw_addr <= SWA_W'(SW_W*SW_W-1)), 1);
            chk($sformatf("run%0d busy_and_done", idx), int'(busy & done), 0);
            if (done) begin
                dcnt++;
                if (dt < 0) dt = t;
            end
            if (busy) begin
                if (bfirst < 0) bfirst = t;
                blast = t;
            end
            if (dt >= 0 && t >= dt + 3) finished = 1'b1;
            t++;
        end
        start = 1'b0;
        stall = 1'b0;
        if (!finished) fail_now($sformatf("run%0d timeout_waiting_done", idx));
        chk($sformatf("run%0d first_en_tb", idx), ftb, rc.first_tb);
        chk($sformatf("run%0d first_en_sw", idx), fsw, rc.first_sw);
        chk($sformatf("run%0d last_en_sw", idx), lsw, rc.last_sw);
        chk($sformatf("run%0d done_cycle", idx), dt, rc.done_at);
        chk($sformatf("run%0d done_count", idx), dcnt, 1);
        chk($sformatf("run%0d busy_first", idx), bfirst, 1);
        chk($sformatf("run%0d busy_last", idx), blast, rc.done_at - 1);
        chk($sformatf("run%0d tb_beats_missing", idx), tbq.size(), 0);
        chk($sformatf("run%0d sw_beats_missing", idx), swq.size(), 0);
        tbq.delete();
        swq.delete();
    endtask

    initial begin
        int dcnt;
        int bcnt;
        //            s1     s2    st2      tb  sw1 swN done
        runs[0] = '{-1, 0, -1, 0, -1, -1,  2, 18, 89, 90};  // plain run
        runs[1] = '{11, 3, 20, 3, -1, -1,  2, 24, 95, 96};  // stalls on TB beat 10 and 16
        runs[2] = '{ 1, 5, -1, 0, -1, -1,  7, 23, 94, 95};  // stall right after start
        runs[3] = '{50, 2, 91, 1, -1, -1,  2, 18, 92, 93};  // stall mid-SW and in drain
        runs[4] = '{-1, 0, -1, 0, 40, 89,  2, 18, 89, 90};  // start ignored while busy

        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl_outputs",
            int'({busy, done, tb_ren, sw_ren, en_tb, en_sw, sw_sol, sw_eol}), 0);
        chk("reset_tb_addr", int'(tb_addr), 0);
        chk("reset_sw_addr", int'(sw_addr), 0);
        chk("reset_cand_dy", int'(cand_dy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            run_one(runs[i], i);
            // Second run immediately after the start-while-busy case.
            if (i == 4) run_one(runs[0], 40);
        end

        // Asynchronous reset in the middle of the SW scan.
        dcnt = 0;
        bcnt = 0;
        for (int t = 0; t < 130; t++) begin
            @(posedge clk); #1;
            start = (t == 0);
            if (t == 50) rst_n = 1'b0;
            if (t == 51) rst_n = 1'b1;
            @(negedge clk);
            if (t == 49) chk("midscan_sw_ren_before_reset", int'({busy, sw_ren, en_sw}), 7);
            if (t == 50) begin
                chk("midscan_reset_ctrl_outputs",
                    int'({busy, done, tb_ren, sw_ren, en_tb, en_sw, sw_sol, sw_eol}), 0);
                chk("midscan_reset_sw_addr", int'(sw_addr), 0);
                chk("midscan_reset_cand_dy", int'(cand_dy), 0);
            end
            if (t >= 50) begin
                if (done) dcnt++;
                if (busy || en_sw || sw_ren) bcnt++;
            end
        end
        start = 1'b0;
        chk("midscan_reset_no_done", dcnt, 0);
        chk("midscan_reset_stays_idle", bcnt, 0);
        run_one(runs[0], 50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
